// File: rtl/op_buf_pkg.sv
// Shared status encodings and helpers for the op_result_buffer slice.
package op_buf_pkg;

    localparam logic [3:0] ST_OK  = 4'b0000;
    localparam logic [3:0] ST_OVF = 4'b1001;

    // Bit 3 of the adder status marks an overflow result.
    function automatic logic is_err(input logic [3:0] status);
        return status[3];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the counter at 1 so that event is not lost.
module sat_counter
    import op_buf_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/op_result_buffer.sv
// Result FIFO behind the bit-clear adder with overflow error accounting.
// Optional OP_BUF_ERROR_DROP_EN: error entries are counted but not stored.
module op_result_buffer
    import op_buf_pkg::*;
#(
    parameter int K     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [K-1:0]             i_cache_result,
    input  logic [3:0]               i_cache_status,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [K-1:0]             o_result,
    output logic [3:0]               o_status,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic                     o_err_sticky,
    input  logic                     i_clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]   status;
        logic [K-1:0] result;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         wr_entry;
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           in_err;
    logic           accept;
    logic           push;
    logic           pop;
    logic           err_acc;

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; ready depends only on registered occupancy, never on the far side.
    assign o_ready = (count != CW'(DEPTH));
    assign o_valid = (count != '0);
    assign o_count = count;

    assign in_err  = is_err(i_cache_status);
    assign accept  = i_valid && o_ready;
    assign err_acc = accept && in_err;
    assign pop     = o_valid && i_ready;

`ifdef OP_BUF_ERROR_DROP_EN
    assign push = accept && !in_err;
`else
    assign push = accept;
`endif

    // Overflow results carry X from the adder, so they are stored as zero.
    always_comb begin
        wr_entry.status = i_cache_status;
        wr_entry.result = in_err ? '0 : i_cache_result;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wptr] <= wr_entry;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_result = o_valid ? mem[rptr].result : '0;
    assign o_status = o_valid ? mem[rptr].status : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err_sticky <= 1'b0;
        end else if (i_clr_err) begin
            o_err_sticky <= err_acc;
        end else if (err_acc) begin
            o_err_sticky <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .clr (i_clr_err),
        .inc (err_acc),
        .cnt (o_err_cnt)
    );

endmodule

// File: tb/tb_op_result_buffer.sv
// Directed bench for op_result_buffer (DEPTH=4), plus a CNT_W=2 instance
// for counter saturation; expectations follow OP_BUF_ERROR_DROP_EN.
module tb_op_result_buffer;
    import op_buf_pkg::*;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       ready_out;
    logic [7:0] cres;
    logic [3:0] cst;
    logic       ovalid;
    logic       cons_ready;
    logic [7:0] ores;
    logic [3:0] ost;
    logic [2:0] ocount;
    logic [7:0] err_cnt;
    logic       sticky;
    logic       clr_err;

    logic       s_valid;
    logic       s_ready_out;
    logic       s_ovalid;
    logic [7:0] s_ores;
    logic [3:0] s_ost;
    logic [2:0] s_count;
    logic [1:0] s_err_cnt;
    logic       s_sticky;
    logic       s_clr;

    int n_compared;
    int n_mismatched;
    logic [11:0] exp_q [$];
    logic [11:0] exp_e;

    op_result_buffer #(.K(8), .DEPTH(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_out),
        .i_cache_result(cres), .i_cache_status(cst), .o_valid(ovalid),
        .i_ready(cons_ready), .o_result(ores), .o_status(ost), .o_count(ocount),
        .o_err_cnt(err_cnt), .o_err_sticky(sticky), .i_clr_err(clr_err)
    );

    op_result_buffer #(.K(8), .DEPTH(4), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready_out),
        .i_cache_result(cres), .i_cache_status(cst), .o_valid(s_ovalid),
        .i_ready(1'b1), .o_result(s_ores), .o_status(s_ost), .o_count(s_count),
        .o_err_cnt(s_err_cnt), .o_err_sticky(s_sticky), .i_clr_err(s_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic [3:0] s);
        valid = v;
        cres  = r;
        cst   = s;
    endtask

    task automatic check_head(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            exp_e = exp_q.pop_front();
            check({tag, "_valid"}, {31'd0, ovalid}, 32'd1);
            check({tag, "_data"}, {20'd0, ost, ores}, {20'd0, exp_e});
        end
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        rst = 1'b1;
        drive(1'b0, 8'h00, ST_OK);
        cons_ready = 1'b0;
        clr_err = 1'b0;
        s_valid = 1'b0;
        s_clr = 1'b0;
        step();
        step();
        check("rst_valid", {31'd0, ovalid}, 32'd0);
        check("rst_ready", {31'd0, ready_out}, 32'd1);
        check("rst_result", {24'd0, ores}, 32'd0);
        check("rst_status", {28'd0, ost}, 32'd0);
        check("rst_count", {29'd0, ocount}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_sticky", {31'd0, sticky}, 32'd0);
        rst = 1'b0;

        // single push then pop
        drive(1'b1, 8'h05, ST_OK);
        step();
        drive(1'b0, 8'h00, ST_OK);
        check("t1_valid", {31'd0, ovalid}, 32'd1);
        check("t1_result", {24'd0, ores}, 32'h05);
        check("t1_count", {29'd0, ocount}, 32'd1);
        cons_ready = 1'b1;
        step();
        cons_ready = 1'b0;
        check("t1_popped", {31'd0, ovalid}, 32'd0);

        // fill to full, refused fifth push, drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), ST_OK);
            exp_q.push_back({ST_OK, 8'(i)});
            step();
        end
        check("full_count", {29'd0, ocount}, 32'd4);
        check("full_ready", {31'd0, ready_out}, 32'd0);
        drive(1'b1, 8'h05, ST_OK);
        step();
        drive(1'b0, 8'h00, ST_OK);
        check("fifth_ignored", {29'd0, ocount}, 32'd4);
        cons_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("drain");
            step();
            if (i == 0) check("ready_after_pop", {31'd0, ready_out}, 32'd1);
        end
        cons_ready = 1'b0;
        check("drain_empty", {31'd0, ovalid}, 32'd0);

        // streaming at occupancy 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h10 + 8'(i), ST_OK);
            exp_q.push_back({ST_OK, 8'h10 + 8'(i)});
            step();
        end
        cons_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'h12 + 8'(i), 4'(i & 3'h7));
            check_head("stream");
            exp_q.push_back({4'(i & 3'h7), 8'h12 + 8'(i)});
            step();
            check("stream_count", {29'd0, ocount}, 32'd2);
        end
        drive(1'b0, 8'h00, ST_OK);
        for (int i = 0; i < 2; i++) begin
            check_head("stream_tail");
            step();
        end
        cons_ready = 1'b0;
        check("stream_empty", {29'd0, ocount}, 32'd0);

        // overflow entry carrying X on the result
        drive(1'b1, 8'hxx, ST_OVF);
        step();
        drive(1'b0, 8'h00, ST_OK);
`ifdef OP_BUF_ERROR_DROP_EN
        check("err_dropped", {31'd0, ovalid}, 32'd0);
        check("err_drop_count", {29'd0, ocount}, 32'd0);
`else
        check("err_valid", {31'd0, ovalid}, 32'd1);
        check("err_result", {24'd0, ores}, 32'd0);
        check("err_status", {28'd0, ost}, 32'h9);
`endif
        check("err_cnt_1", {24'd0, err_cnt}, 32'd1);
        check("err_sticky_1", {31'd0, sticky}, 32'd1);
        drive(1'b1, 8'hA5, 4'b1100);
        step();
        drive(1'b0, 8'h00, ST_OK);
`ifdef OP_BUF_ERROR_DROP_EN
        check("err2_dropped", {29'd0, ocount}, 32'd0);
`else
        check("err2_count", {29'd0, ocount}, 32'd2);
`endif
        check("err_cnt_2", {24'd0, err_cnt}, 32'd2);
        cons_ready = 1'b1;
        step();
`ifndef OP_BUF_ERROR_DROP_EN
        check("err2_result", {24'd0, ores}, 32'd0);
        check("err2_status", {28'd0, ost}, 32'hC);
`endif
        step();
        cons_ready = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_cnt", {24'd0, err_cnt}, 32'd0);
        check("clr_sticky", {31'd0, sticky}, 32'd0);

        // saturation on the 2-bit counter instance
        cst = ST_OVF;
        cres = 8'h77;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt", {30'd0, s_err_cnt}, 32'd3);
        check("sat_sticky", {31'd0, s_sticky}, 32'd1);
        s_clr = 1'b1;
        step();
        check("sat_clr_inc_cnt", {30'd0, s_err_cnt}, 32'd1);
        check("sat_clr_inc_sticky", {31'd0, s_sticky}, 32'd1);
        s_valid = 1'b0;
        step();
        s_clr = 1'b0;
        check("sat_clr_cnt", {30'd0, s_err_cnt}, 32'd0);
        check("sat_clr_sticky", {31'd0, s_sticky}, 32'd0);
        check("sat_main_untouched", {24'd0, err_cnt}, 32'd0);

        // asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h21 + 8'(i), ST_OK);
            step();
        end
        drive(1'b0, 8'h00, ST_OK);
        check("pre_rst_count", {29'd0, ocount}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, ovalid}, 32'd0);
        check("arst_count", {29'd0, ocount}, 32'd0);
        check("arst_ready", {31'd0, ready_out}, 32'd1);
        check("arst_result", {24'd0, ores}, 32'd0);
        check("arst_status", {28'd0, ost}, 32'd0);
        #1;
        rst = 1'b0;
        step();
        drive(1'b1, 8'h33, 4'b0010);
        step();
        drive(1'b0, 8'h00, ST_OK);
        check("post_rst_count", {29'd0, ocount}, 32'd1);
        check("post_rst_data", {20'd0, ost, ores}, 32'h233);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/op_result_buffer.md
# op_result_buffer

Registered result buffer directly downstream of the bit-clear adder stage. Captures each `cache_result`/`cache_status` pair the adder produces into a small FIFO and presents entries to the consumer through a valid/ready handshake. Also keeps a saturating error counter and a sticky error flag for overflow statuses (`status[3]` set, for example `4'b1001`).

## Interface

Parameters:
- `K`, default 8: result width; matches the adder's `K`.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `CNT_W`, default 8: error counter width.

Ports:
- `i_clk`, in, 1: single clock; all state updates on the rising edge.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_valid`, in, 1: the adder output is valid this cycle.
- `o_ready`, out, 1: the buffer can accept an entry.
- `i_cache_result`, in, K: result from the adder.
- `i_cache_status`, in, 4: status from the adder.
- `o_valid`, out, 1: the head entry is valid.
- `i_ready`, in, 1: the consumer accepts the head entry.
- `o_result`, out, K: head result.
- `o_status`, out, 4: head status.
- `o_count`, out, $clog2(DEPTH)+1: current occupancy.
- `o_err_cnt`, out, CNT_W: saturating count of error entries accepted.
- `o_err_sticky`, out, 1: set on any accepted error entry.
- `i_clr_err`, in, 1: synchronous clear of `o_err_cnt` and `o_err_sticky`.

## Operation

- Push occurs when `i_valid && o_ready`.
- Pop occurs when `o_valid && i_ready`.
- Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Occupancy register `o_count` changes as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- `o_ready = (o_count != DEPTH)`.
  - When full, a push is not accepted even if a pop occurs in the same cycle.
  - This is deliberate: it removes any combinational ready path from `i_ready` to `o_ready`.
- `o_valid = (o_count != 0)`.
- `o_result` and `o_status` are driven from the head entry.
  - When empty, both are forced to 0.
- Error entry: an accepted entry with `i_cache_status[3] == 1`.
  - Its result is stored as `{K{1'b0}}`; the adder drives X on overflow, and X must never be stored.
  - Its status is stored unchanged.
- Error counter:
  - `o_err_cnt` increments on each accepted error entry and saturates at 2^CNT_W−1.
  - `o_err_sticky` sets on each accepted error entry.
- `i_clr_err` has priority over accumulated state, but the same-cycle event is not lost.
  - If an error entry is accepted in the same cycle as `i_clr_err`, then `o_err_cnt` becomes 1 and `o_err_sticky` becomes 1.
- Reset mid-operation: all contents are discarded and pointers return to 0.
  - Stale memory contents are never visible, because `o_valid = 0` whenever `o_count = 0`.

## Timing

- Values on reset:
  - `o_valid=0`, `o_ready=1`, `o_result=0`, `o_status=0`.
  - `o_count=0`, `o_err_cnt=0`, `o_err_sticky=0`.
- Latency: a push in cycle N gives `o_valid=1` with that data in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle are sustained when the buffer is neither empty nor full.
- After a pop from a full buffer, `o_ready` rises in the next cycle.
- All outputs are functions of registered state only; there are no input-to-output combinational paths.

## Configuration

- `OP_BUF_ERROR_DROP_EN` defined:
  - Error entries are counted and flag the sticky bit, but are not written to the FIFO.
  - Pointers and `o_count` are unchanged for them.
  - `o_ready` is still reported normally; a full buffer refuses error entries too, and they are not counted until accepted.
- Macro undefined: error entries are stored, with the result zeroed as described in Operation.

## Structure

- Package `op_buf_pkg` holds:
  - `ST_OK = 4'b0000`.
  - `ST_OVF = 4'b1001`.
  - `function is_err(status)`, which returns `status[3]`.
  - A parameterised packed struct `entry_t {logic [3:0] status; logic [K-1:0] result;}`, or an equivalent concatenation helper.
- One sub-module, `sat_counter`, holds the saturating counter with clear and increment inputs, parameterised by `CNT_W`.

## Test plan

All scenarios use `DEPTH=4`.

- Reset, then push A=`8'h05`/`4'b0000` with `i_ready=0`:
  - Next cycle `o_valid=1`, `o_result=8'h05`, `o_count=1`.
  - Assert `i_ready` → popped; `o_valid=0` the cycle after.
- Push `8'h01`..`8'h04` with `i_ready=0`:
  - `o_count=4` and `o_ready=0`.
  - A fifth push is ignored.
  - Drain yields 01, 02, 03, 04 in order; `o_ready=1` one cycle after the first pop.
- Continuous push and pop at `o_count=2` for 10 cycles:
  - `o_count` stays 2.
  - Outputs are in order across pointer wrap.
- Push a status `4'b1001` entry with X on the result:
  - Macro off: `o_result=0`, `o_status=4'b1001`, `o_err_cnt=1`, `o_err_sticky=1`.
  - Macro on: `o_valid` stays 0 and `o_err_cnt=1`.
- `CNT_W=2`: push 5 error entries → `o_err_cnt=3` (saturated). Then `i_clr_err` together with an error push → `o_err_cnt=1`, `o_err_sticky=1`.
- Assert `i_rst` asynchronously while `o_count=3`:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - After deassertion, the first push reads back correctly.
